// File: rtl/zip_dblbus_arbiter_if.sv
// rtl/zip_dblbus_arbiter_if.sv - pipelined global/local Wishbone link between one master and one slave
interface zip_dblbus_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic            cyc_gbl;
  logic            cyc_lcl;
  logic            stb_gbl;
  logic            stb_lcl;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] sel;
  logic            stall;
  logic            ack;
  logic            err;

  modport master (
    output cyc_gbl, cyc_lcl, stb_gbl, stb_lcl, we, addr, data, sel,
    input  stall, ack, err
  );

  modport slave (
    input  cyc_gbl, cyc_lcl, stb_gbl, stb_lcl, we, addr, data, sel,
    output stall, ack, err
  );
endinterface

// File: rtl/zip_dblbus_arbiter.sv
// rtl/zip_dblbus_arbiter.sv - parks one dual Wishbone bus on master A or B, tracks
// outstanding requests, filters stray acks and aborts hung cycles with a watchdog.
module zip_dblbus_arbiter #(
  parameter int AW               = 30,
  parameter int DW               = 32,
  parameter int LGOUTSTANDING    = 4,
  parameter int LGTIMEOUT        = 10,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  zip_dblbus_arbiter_if.slave  i_a,
  zip_dblbus_arbiter_if.slave  i_b,
  zip_dblbus_arbiter_if.master o_bus,
  output logic                 o_owner
);
  typedef enum logic {OWN_B = 1'b0, OWN_A = 1'b1} owner_t;

  owner_t                   r_owner, w_owner_next;
  logic [LGOUTSTANDING-1:0] r_count;
  logic                     w_abort;
  logic                     w_a_cyc, w_b_cyc;
  logic                     w_m_cyc_gbl, w_m_cyc_lcl, w_m_stb_gbl, w_m_stb_lcl, w_m_we;
  logic [AW-1:0]            w_m_addr;
  logic [DW-1:0]            w_m_data;
  logic [DW/8-1:0]          w_m_sel;
  logic                     w_live, w_full;
  logic                     w_cyc_gbl, w_cyc_lcl, w_stb_gbl, w_stb_lcl, w_any_cyc;
  logic                     w_accept, w_fwd_ack;
  logic                     w_own_stall, w_own_ack, w_own_err;

  assign w_a_cyc = i_a.cyc_gbl | i_a.cyc_lcl;
  assign w_b_cyc = i_b.cyc_gbl | i_b.cyc_lcl;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_owner <= OWN_A;
    else            r_owner <= w_owner_next;
  end

  // Ownership moves only when the current owner has released cyc.
  always_comb begin
    w_owner_next = r_owner;
    case (r_owner)
      OWN_A:   if (!w_a_cyc && w_b_cyc) w_owner_next = OWN_B;
      default: if (!w_b_cyc && w_a_cyc) w_owner_next = OWN_A;
    endcase
  end

  always_comb begin
    if (r_owner == OWN_A) begin
      w_m_cyc_gbl = i_a.cyc_gbl;
      w_m_cyc_lcl = i_a.cyc_lcl;
      w_m_stb_gbl = i_a.stb_gbl;
      w_m_stb_lcl = i_a.stb_lcl;
      w_m_we      = i_a.we;
      w_m_addr    = i_a.addr;
      w_m_data    = i_a.data;
      w_m_sel     = i_a.sel;
    end else begin
      w_m_cyc_gbl = i_b.cyc_gbl;
      w_m_cyc_lcl = i_b.cyc_lcl;
      w_m_stb_gbl = i_b.stb_gbl;
      w_m_stb_lcl = i_b.stb_lcl;
      w_m_we      = i_b.we;
      w_m_addr    = i_b.addr;
      w_m_data    = i_b.data;
      w_m_sel     = i_b.sel;
    end
  end

  assign w_live    = i_reset_n && !w_abort;
  assign w_full    = (r_count == '1);
  assign w_cyc_gbl = w_live && w_m_cyc_gbl;
  assign w_cyc_lcl = w_live && w_m_cyc_lcl;
  assign w_stb_gbl = w_live && !w_full && w_m_stb_gbl;
  assign w_stb_lcl = w_live && !w_full && w_m_stb_lcl;
  assign w_any_cyc = w_cyc_gbl || w_cyc_lcl;
  assign w_accept  = (w_stb_gbl || w_stb_lcl) && !o_bus.stall;
  assign w_fwd_ack = o_bus.ack && w_any_cyc && (r_count != '0);

  assign w_own_stall = !i_reset_n || o_bus.stall || w_full || w_abort;
  assign w_own_ack   = w_fwd_ack;
  assign w_own_err   = i_reset_n && (o_bus.err || w_abort);

  always_comb begin
    o_bus.cyc_gbl = w_cyc_gbl;
    o_bus.cyc_lcl = w_cyc_lcl;
    o_bus.stb_gbl = w_stb_gbl;
    o_bus.stb_lcl = w_stb_lcl;
    o_bus.we      = w_m_we;
    o_bus.addr    = w_m_addr;
    o_bus.data    = w_m_data;
    o_bus.sel     = w_m_sel;
    if (OPT_ZERO_ON_IDLE && !w_any_cyc) begin
      o_bus.we   = 1'b0;
      o_bus.addr = '0;
      o_bus.data = '0;
      o_bus.sel  = '0;
    end
    i_a.stall = 1'b1;
    i_a.ack   = 1'b0;
    i_a.err   = 1'b0;
    i_b.stall = 1'b1;
    i_b.ack   = 1'b0;
    i_b.err   = 1'b0;
    if (r_owner == OWN_A) begin
      i_a.stall = w_own_stall;
      i_a.ack   = w_own_ack;
      i_a.err   = w_own_err;
    end else begin
      i_b.stall = w_own_stall;
      i_b.ack   = w_own_ack;
      i_b.err   = w_own_err;
    end
  end

  // Accept and forwarded ack in the same cycle cancel out.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_count <= '0;
    else if (o_bus.err || w_abort || !w_any_cyc)
      r_count <= '0;
    else if (w_accept && !w_fwd_ack)
      r_count <= r_count + 1'b1;
    else if (!w_accept && w_fwd_ack)
      r_count <= r_count - 1'b1;
  end

  generate
    if (LGTIMEOUT > 0) begin : g_wdt
      localparam logic [LGTIMEOUT-1:0] TMAX  = '1;
      localparam logic [LGTIMEOUT-1:0] TLAST = TMAX - 1'b1;
      logic [LGTIMEOUT-1:0] r_timer;
      logic                 r_abort;

      // r_abort is a single-cycle pulse: it drops cyc, which clears the timer.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_timer <= '0;
          r_abort <= 1'b0;
        end else begin
          r_abort <= 1'b0;
          if (r_abort || !w_any_cyc || (r_count == '0) || o_bus.ack) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (r_timer == TLAST) r_abort <= 1'b1;
          end
        end
      end
      assign w_abort = r_abort;
    end else begin : g_nowdt
      assign w_abort = 1'b0;
    end
  endgenerate

  assign o_owner = (r_owner == OWN_A);
endmodule

// File: tb/tb_zip_dblbus_arbiter.sv
// tb/tb_zip_dblbus_arbiter.sv - directed self-checking bench for zip_dblbus_arbiter
module tb_zip_dblbus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  zip_dblbus_arbiter_if #(.AW(30), .DW(32)) a_if ();
  zip_dblbus_arbiter_if #(.AW(30), .DW(32)) b_if ();
  zip_dblbus_arbiter_if #(.AW(30), .DW(32)) bus_if ();

  zip_dblbus_arbiter #(
    .AW(30), .DW(32), .LGOUTSTANDING(2), .LGTIMEOUT(4), .OPT_ZERO_ON_IDLE(1'b0)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a_if), .i_b(b_if), .o_bus(bus_if), .o_owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.cyc_gbl = 0; a_if.cyc_lcl = 0; a_if.stb_gbl = 0; a_if.stb_lcl = 0;
    a_if.we = 0; a_if.addr = '0; a_if.data = '0; a_if.sel = '0;
    b_if.cyc_gbl = 0; b_if.cyc_lcl = 0; b_if.stb_gbl = 0; b_if.stb_lcl = 0;
    b_if.we = 0; b_if.addr = '0; b_if.data = '0; b_if.sel = '0;
    bus_if.stall = 0; bus_if.ack = 0; bus_if.err = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    a_if.cyc_gbl = 1; a_if.stb_gbl = 1; a_if.addr = 30'h123;
    b_if.cyc_gbl = 1; b_if.stb_gbl = 1; b_if.addr = 30'h456;
    tick(); tick();
    @(negedge clk);
    n_total++; if (bus_if.cyc_gbl !== 1'b0) $display("FAIL rst_cyc: got %b want 0", bus_if.cyc_gbl); else n_pass++;
    n_total++; if (bus_if.stb_gbl !== 1'b0) $display("FAIL rst_stb: got %b want 0", bus_if.stb_gbl); else n_pass++;
    n_total++; if ({a_if.stall, b_if.stall} !== 2'b11) $display("FAIL rst_stall: got %b want 11", {a_if.stall, b_if.stall}); else n_pass++;
    n_total++; if ({a_if.ack, a_if.err, b_if.ack, b_if.err} !== 4'b0) $display("FAIL rst_ackerr: got %b want 0000", {a_if.ack, a_if.err, b_if.ack, b_if.err}); else n_pass++;
    n_total++; if (owner !== 1'b1) $display("FAIL rst_owner: got %b want 1", owner); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    n_total++; if ({bus_if.cyc_gbl, bus_if.stb_gbl} !== 2'b11) $display("FAIL rel_a_on_bus: got %b want 11", {bus_if.cyc_gbl, bus_if.stb_gbl}); else n_pass++;
    n_total++; if (bus_if.addr !== 30'h123) $display("FAIL rel_addr: got %h want 123", bus_if.addr); else n_pass++;
    n_total++; if ({a_if.stall, b_if.stall} !== 2'b01) $display("FAIL rel_stall: got %b want 01", {a_if.stall, b_if.stall}); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_pipeline();
    for (int c = 0; c < 6; c++) begin
      a_if.cyc_gbl = 1;
      a_if.stb_gbl = (c < 3);
      a_if.addr    = 30'(32'h100 + c);
      bus_if.ack   = (c >= 2 && c < 5);
      @(negedge clk);
      n_total++; if (bus_if.stb_gbl !== (c < 3)) $display("FAIL pipe_stb c%0d: got %b want %b", c, bus_if.stb_gbl, (c < 3)); else n_pass++;
      n_total++; if (a_if.ack !== (c >= 2 && c < 5)) $display("FAIL pipe_ack c%0d: got %b want %b", c, a_if.ack, (c >= 2 && c < 5)); else n_pass++;
      if (c < 3) begin
        n_total++; if (a_if.stall !== 1'b0) $display("FAIL pipe_stall c%0d: got %b want 0", c, a_if.stall); else n_pass++;
        n_total++; if (bus_if.addr !== 30'(32'h100 + c)) $display("FAIL pipe_addr c%0d: got %h want %h", c, bus_if.addr, 32'h100 + c); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (dut.r_count !== 2'd0) $display("FAIL pipe_count: got %0d want 0", dut.r_count); else n_pass++;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_handover();
    for (int c = 0; c < 9; c++) begin
      a_if.cyc_gbl = (c <= 4);
      a_if.stb_gbl = (c == 0);
      a_if.addr    = 30'h200;
      b_if.cyc_gbl = (c >= 1);
      b_if.stb_gbl = (c >= 1 && c <= 6);
      b_if.addr    = 30'h300;
      bus_if.ack   = (c == 1 || c == 7);
      @(negedge clk);
      n_total++; if (owner !== (c < 6)) $display("FAIL ho_owner c%0d: got %b want %b", c, owner, (c < 6)); else n_pass++;
      if (c >= 1 && c <= 6) begin
        n_total++; if (b_if.stall !== (c < 6)) $display("FAIL ho_b_stall c%0d: got %b want %b", c, b_if.stall, (c < 6)); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if ({a_if.ack, b_if.ack} !== 2'b10) $display("FAIL ho_a_ack: got %b want 10", {a_if.ack, b_if.ack}); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (bus_if.cyc_gbl !== 1'b0) $display("FAIL ho_gap_cyc: got %b want 0", bus_if.cyc_gbl); else n_pass++;
      end
      if (c == 6) begin
        n_total++; if ({bus_if.stb_gbl, a_if.stall} !== 2'b11) $display("FAIL ho_b_stb: got %b want 11", {bus_if.stb_gbl, a_if.stall}); else n_pass++;
        n_total++; if (bus_if.addr !== 30'h300) $display("FAIL ho_b_addr: got %h want 300", bus_if.addr); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if ({a_if.ack, b_if.ack} !== 2'b01) $display("FAIL ho_b_ack: got %b want 01", {a_if.ack, b_if.ack}); else n_pass++;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int err_cnt = 0;
    int err_at  = -1;
    logic cyc_at_err = 1'b1;
    a_if.cyc_gbl = 1; a_if.stb_gbl = 1; a_if.addr = 30'h40;
    @(negedge clk);
    n_total++; if ({owner, a_if.stall, bus_if.cyc_gbl} !== 3'b010) $display("FAIL to_grant_wait: got %b want 010", {owner, a_if.stall, bus_if.cyc_gbl}); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({owner, a_if.stall, bus_if.stb_gbl} !== 3'b101) $display("FAIL to_granted: got %b want 101", {owner, a_if.stall, bus_if.stb_gbl}); else n_pass++;
    tick();
    a_if.stb_gbl = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (a_if.err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = k;
          cyc_at_err = bus_if.cyc_gbl;
        end
      end
      tick();
    end
    n_total++; if (err_cnt != 1) $display("FAIL to_err_pulses: got %0d want 1", err_cnt); else n_pass++;
    n_total++; if (err_at != 16) $display("FAIL to_err_cycle: got %0d want 16", err_at); else n_pass++;
    n_total++; if (cyc_at_err !== 1'b0) $display("FAIL to_cyc_dropped: got %b want 0", cyc_at_err); else n_pass++;
    n_total++; if ({owner, dut.r_count} !== 3'b100) $display("FAIL to_after: got %b want 100", {owner, dut.r_count}); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_outstanding();
    for (int c = 0; c < 7; c++) begin
      a_if.cyc_gbl = 1;
      a_if.stb_gbl = (c <= 5);
      bus_if.ack   = (c == 4);
      @(negedge clk);
      if (c <= 5) begin
        n_total++; if (a_if.stall !== (c == 3 || c == 4)) $display("FAIL os_stall c%0d: got %b want %b", c, a_if.stall, (c == 3 || c == 4)); else n_pass++;
        n_total++; if (bus_if.stb_gbl !== !(c == 3 || c == 4)) $display("FAIL os_stb c%0d: got %b want %b", c, bus_if.stb_gbl, !(c == 3 || c == 4)); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if (a_if.ack !== 1'b1) $display("FAIL os_ack: got %b want 1", a_if.ack); else n_pass++;
      end
      if (c == 6) begin
        n_total++; if ({dut.r_count, a_if.stall} !== 3'b111) $display("FAIL os_full: got %b want 111", {dut.r_count, a_if.stall}); else n_pass++;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious_and_err();
    a_if.cyc_gbl = 1; bus_if.ack = 1;
    @(negedge clk);
    n_total++; if (a_if.ack !== 1'b0) $display("FAIL sp_ack_cnt0: got %b want 0", a_if.ack); else n_pass++;
    tick();
    bus_if.ack = 0; a_if.stb_gbl = 1;
    tick(); tick();
    a_if.stb_gbl = 0; bus_if.err = 1;
    @(negedge clk);
    n_total++; if ({a_if.err, b_if.err, a_if.ack} !== 3'b100) $display("FAIL sp_err_fwd: got %b want 100", {a_if.err, b_if.err, a_if.ack}); else n_pass++;
    n_total++; if (dut.r_count !== 2'd2) $display("FAIL sp_pre_err_count: got %0d want 2", dut.r_count); else n_pass++;
    tick();
    bus_if.err = 0;
    @(negedge clk);
    n_total++; if (dut.r_count !== 2'd0) $display("FAIL sp_err_clear: got %0d want 0", dut.r_count); else n_pass++;
    tick();
    clear_inputs(); bus_if.ack = 1;
    @(negedge clk);
    n_total++; if ({a_if.ack, b_if.ack} !== 2'b00) $display("FAIL sp_ack_idle: got %b want 00", {a_if.ack, b_if.ack}); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midcycle();
    a_if.cyc_gbl = 1; a_if.stb_gbl = 1;
    tick();
    a_if.stb_gbl = 0;
    #2;
    rst_n = 0; bus_if.ack = 1;
    #1;
    n_total++; if ({bus_if.cyc_gbl, a_if.ack, a_if.stall} !== 3'b001) $display("FAIL mr_drop: got %b want 001", {bus_if.cyc_gbl, a_if.ack, a_if.stall}); else n_pass++;
    n_total++; if (dut.r_count !== 2'd0) $display("FAIL mr_count: got %0d want 0", dut.r_count); else n_pass++;
    tick();
    rst_n = 1;
    @(negedge clk);
    n_total++; if (a_if.ack !== 1'b0) $display("FAIL mr_stale_ack: got %b want 0", a_if.ack); else n_pass++;
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_pipeline();
    test_handover();
    test_timeout();
    test_outstanding();
    test_spurious_and_err();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
